// File: rtl/coded_lock_seq.sv
// coded_lock_seq
// Keypad-style coded lock. Digits arrive one per enter pulse. When a full code
// has been entered it is compared with the stored code. A match opens the
// lock for a fixed time, and while open the code can be reprogrammed. A
// mismatch raises a timed alarm. Running out of tries forces a longer lockout.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   code_in     digit value, sampled on enter
//   enter       single-cycle digit strobe
//   cancel      single-cycle abort strobe (wins over enter)
//   prog        level, requests code programming while open
//   open        lock released (OPEN and PROG)
//   alarm       wrong code / lockout indicator
//   locked_out  lockout indicator
//   tries_left  remaining attempts before lockout
//   seg_led_1   seven-segment pattern of digits entered so far
//   seg_led_2   seven-segment pattern of tries_left
module coded_lock_seq #(
    parameter int DIGIT_W = 4,
    parameter int NUM_DIGITS = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_TRIES = 3,
    parameter int OPEN_CYCLES = 50_000_000,
    parameter int ALARM_CYCLES = 12_000_000,
    parameter int LOCK_CYCLES = 120_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIGIT_W-1:0]               code_in,
    input  logic                             enter,
    input  logic                             cancel,
    input  logic                             prog,
    output logic                             open,
    output logic                             alarm,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic [8:0]                       seg_led_1,
    output logic [8:0]                       seg_led_2
);

    localparam int CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int MAX_AO  = (OPEN_CYCLES > ALARM_CYCLES) ? OPEN_CYCLES : ALARM_CYCLES;
    localparam int MAX_CYC = (MAX_AO > LOCK_CYCLES) ? MAX_AO : LOCK_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        PROG,
        FAIL,
        LOCKOUT
    } state_t;

    state_t              state, state_n;
    logic [CODE_W-1:0]   code_reg, code_n;
    logic [CODE_W-1:0]   buffer, buf_n;
    logic [CODE_W-1:0]   shifted;
    logic [CNT_W-1:0]    digit_cnt, cnt_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    logic [TRY_W-1:0]    tries_n;
    logic                last_digit;

    function automatic logic [8:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 9'h03f;
            4'd1:    seg7 = 9'h006;
            4'd2:    seg7 = 9'h05b;
            4'd3:    seg7 = 9'h04f;
            4'd4:    seg7 = 9'h066;
            4'd5:    seg7 = 9'h06d;
            4'd6:    seg7 = 9'h07d;
            4'd7:    seg7 = 9'h007;
            4'd8:    seg7 = 9'h07f;
            4'd9:    seg7 = 9'h06f;
            default: seg7 = 9'h000;
        endcase
    endfunction

    // The first digit entered ends up most significant after NUM_DIGITS shifts.
    assign shifted    = {buffer[CODE_W-DIGIT_W-1:0], code_in};
    assign last_digit = (digit_cnt + CNT_W'(1)) == CNT_W'(NUM_DIGITS);

    // Next-state logic. One shared timer is used because only one timed
    // state can be active at a time. It restarts from 0 whenever it is not
    // explicitly advanced.
    always_comb begin
        state_n = state;
        code_n  = code_reg;
        buf_n   = buffer;
        cnt_n   = digit_cnt;
        timer_n = '0;
        tries_n = tries_left;
        case (state)
            IDLE: begin
                if (enter && !cancel) begin
                    buf_n   = CODE_W'(code_in);
                    cnt_n   = CNT_W'(1);
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (enter) begin
                    buf_n = shifted;
                    cnt_n = digit_cnt + CNT_W'(1);
                    if (last_digit) state_n = CHECK;
                end
            end
            CHECK: begin
                buf_n = '0;
                cnt_n = '0;
                if (buffer == code_reg) begin
                    tries_n = TRY_W'(MAX_TRIES);
                    state_n = OPEN;
                end else begin
                    tries_n = tries_left - TRY_W'(1);
                    state_n = (tries_n == '0) ? LOCKOUT : FAIL;
                end
            end
            OPEN: begin
                if (cancel) begin
                    state_n = IDLE;
                end else if (enter && prog) begin
                    // The new code is collected in the entry buffer and is
                    // only copied into code_reg once it is complete.
                    buf_n   = CODE_W'(code_in);
                    cnt_n   = CNT_W'(1);
                    state_n = PROG;
                end else if (timer == TIMER_W'(OPEN_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            PROG: begin
                if (cancel) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (enter) begin
                    if (last_digit) begin
                        code_n  = shifted;
                        buf_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        buf_n = shifted;
                        cnt_n = digit_cnt + CNT_W'(1);
                    end
                end
            end
            FAIL: begin
                if (timer == TIMER_W'(ALARM_CYCLES - 1)) state_n = IDLE;
                else timer_n = timer + TIMER_W'(1);
            end
            LOCKOUT: begin
                if (timer == TIMER_W'(LOCK_CYCLES - 1)) begin
                    tries_n = TRY_W'(MAX_TRIES);
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            default: begin
                buf_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State register. The outputs are registered from the next-state values,
    // so that they change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            code_reg   <= DEFAULT_CODE;
            buffer     <= '0;
            digit_cnt  <= '0;
            timer      <= '0;
            tries_left <= TRY_W'(MAX_TRIES);
            open       <= 1'b0;
            alarm      <= 1'b0;
            locked_out <= 1'b0;
            seg_led_1  <= seg7(4'd0);
            seg_led_2  <= seg7(4'(MAX_TRIES));
        end else begin
            state      <= state_n;
            code_reg   <= code_n;
            buffer     <= buf_n;
            digit_cnt  <= cnt_n;
            timer      <= timer_n;
            tries_left <= tries_n;
            open       <= (state_n == OPEN) || (state_n == PROG);
            alarm      <= (state_n == FAIL) || (state_n == LOCKOUT);
            locked_out <= (state_n == LOCKOUT);
            seg_led_1  <= seg7(4'(cnt_n));
            seg_led_2  <= seg7(4'(tries_n));
        end
    end

endmodule

// File: tb/tb_coded_lock_seq.sv
// tb_coded_lock_seq
// Scenario bench for coded_lock_seq with short timers. Each scenario queues a
// per-cycle plan of inputs and the outputs expected after that edge. play()
// drives one step and pushes its expectation. The scenario then pops the
// expectation and compares it with the sampled outputs.
module tb_coded_lock_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code_in = 4'd0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;
    logic       prog = 1'b0;
    logic       open;
    logic       alarm;
    logic       locked_out;
    logic [1:0] tries_left;
    logic [8:0] seg_led_1;
    logic [8:0] seg_led_2;

    int total = 0;
    int bad = 0;

    logic [8:0] seg_tab [0:9] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                                  9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

    typedef struct {
        logic       r, e, c, p;
        logic [3:0] cd;
        logic       o, a, l;
        logic [1:0] t;
        int         d;
    } step_t;

    step_t       plan_q[$];
    logic [22:0] exp_q[$];

    coded_lock_seq #(
        .OPEN_CYCLES(8),
        .ALARM_CYCLES(4),
        .LOCK_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .code_in(code_in),
        .enter(enter),
        .cancel(cancel),
        .prog(prog),
        .open(open),
        .alarm(alarm),
        .locked_out(locked_out),
        .tries_left(tries_left),
        .seg_led_1(seg_led_1),
        .seg_led_2(seg_led_2)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic c, input logic p,
                       input logic [3:0] cd, input logic o, input logic a,
                       input logic l, input logic [1:0] t, input int d);
        step_t s;
        s.r = r; s.e = e; s.c = c; s.p = p; s.cd = cd;
        s.o = o; s.a = a; s.l = l; s.t = t; s.d = d;
        plan_q.push_back(s);
    endtask

    task automatic idle(input int n, input logic o, input logic a, input logic l,
                        input logic [1:0] t, input int d);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 4'd0, o, a, l, t, d);
    endtask

    // Four ordinary digit entries from IDLE. The display counts 1..4 while
    // the lock stays shut.
    task automatic digits(input logic [15:0] code, input logic [1:0] t);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, code[15-4*i -: 4], 0, 0, 0, t, i + 1);
    endtask

    task automatic play();
        step_t s;
        s = plan_q.pop_front();
        rst = s.r; enter = s.e; cancel = s.c; prog = s.p; code_in = s.cd;
        exp_q.push_back({s.o, s.a, s.l, s.t, seg_tab[s.d], seg_tab[s.t]});
        @(posedge clk);
        #1;
        rst = 1'b0; enter = 1'b0; cancel = 1'b0; prog = 1'b0; code_in = 4'd0;
    endtask

    task automatic test_reset();
        logic [22:0] e, obs;
        int n = 0;
        add(1, 0, 0, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        add(1, 1, 0, 0, 4'd1, 0, 0, 0, 2'd3, 0);
        idle(2, 0, 0, 0, 2'd3, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL reset step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_unlock();
        logic [22:0] e, obs;
        int n = 0;
        digits(16'h1234, 2'd3);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        idle(7, 1, 0, 0, 2'd3, 0);
        idle(2, 0, 0, 0, 2'd3, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL unlock step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_lockout();
        logic [22:0] e, obs;
        int n = 0;
        for (int k = 0; k < 2; k++) begin
            digits(16'h1235, 2'(3 - k));
            idle(4, 0, 1, 0, 2'(2 - k), 0);
            idle(1, 0, 0, 0, 2'(2 - k), 0);
        end
        digits(16'h1235, 2'd1);
        for (int i = 0; i < 16; i++)
            add(0, 1'(i % 2), 0, 0, 4'd1, 0, 1, 1, 2'd0, 0);
        idle(2, 0, 0, 0, 2'd3, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL lockout step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_cancel();
        logic [22:0] e, obs;
        int n = 0;
        add(0, 1, 0, 0, 4'd1, 0, 0, 0, 2'd3, 1);
        add(0, 1, 0, 0, 4'd2, 0, 0, 0, 2'd3, 2);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        add(0, 1, 1, 0, 4'd1, 0, 0, 0, 2'd3, 0);
        add(0, 1, 0, 0, 4'd1, 0, 0, 0, 2'd3, 1);
        add(0, 1, 1, 0, 4'd2, 0, 0, 0, 2'd3, 0);
        digits(16'h1234, 2'd3);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 1, 0, 0, 4'd5, 1, 0, 0, 2'd3, 0);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        digits(16'h1111, 2'd3);
        idle(2, 0, 1, 0, 2'd2, 0);
        add(0, 1, 1, 0, 4'd1, 0, 1, 0, 2'd2, 0);
        add(0, 1, 0, 0, 4'd3, 0, 1, 0, 2'd2, 0);
        idle(1, 0, 0, 0, 2'd2, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL cancel step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_prog();
        logic [22:0] e, obs;
        int n = 0;
        digits(16'h1234, 2'd2);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 1, 0, 1, 4'd9, 1, 0, 0, 2'd3, 1);
        add(0, 1, 0, 1, 4'd8, 1, 0, 0, 2'd3, 2);
        idle(10, 1, 0, 0, 2'd3, 2);
        add(0, 1, 0, 1, 4'd7, 1, 0, 0, 2'd3, 3);
        add(0, 1, 0, 1, 4'd6, 0, 0, 0, 2'd3, 0);
        digits(16'h1234, 2'd3);
        idle(4, 0, 1, 0, 2'd2, 0);
        idle(1, 0, 0, 0, 2'd2, 0);
        digits(16'h9876, 2'd2);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 1, 0, 1, 4'd1, 1, 0, 0, 2'd3, 1);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        digits(16'h9876, 2'd3);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL prog step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e, obs;
        int n = 0;
        digits(16'h9876, 2'd3);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 1, 0, 1, 4'd5, 1, 0, 0, 2'd3, 1);
        add(0, 1, 0, 1, 4'd5, 1, 0, 0, 2'd3, 2);
        add(1, 0, 0, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        digits(16'h1234, 2'd3);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 2'd3, 0);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        for (int k = 0; k < 2; k++) begin
            digits(16'h1235, 2'(3 - k));
            idle(4, 0, 1, 0, 2'(2 - k), 0);
            idle(1, 0, 0, 0, 2'(2 - k), 0);
        end
        digits(16'h1235, 2'd1);
        idle(5, 0, 1, 1, 2'd0, 0);
        add(1, 0, 0, 0, 4'd0, 0, 0, 0, 2'd3, 0);
        idle(2, 0, 0, 0, 2'd3, 0);
        while (plan_q.size() > 0) begin
            play();
            e = exp_q.pop_front();
            obs = {open, alarm, locked_out, tries_left, seg_led_1, seg_led_2};
            total++;
            if (obs !== e) begin
                bad++;
                $display("[TB] FAIL reset_mid step %0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        $display("[TB] coded_lock_seq scenarios starting");
        test_reset();
        test_unlock();
        test_lockout();
        test_cancel();
        test_prog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
